// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings for the byte-enable data memory
package dm_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [3:0] LANE_ALL     = 4'b1111;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_BYTE0   = 4'b0001;

endpackage

// File: rtl/dm_align.sv
// rtl/dm_align.sv - lane mask, store replication, alignment check and load extraction
module dm_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        sext,
    input  logic [31:0] raw,
    output logic [3:0]  mask,
    output logic [31:0] wword,
    output logic        misalign,
    output logic [31:0] ldata
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (addr_lo)
            2'd0:    byte_v = raw[7:0];
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            default: byte_v = raw[31:24];
        endcase

        // size 2'b11 falls through to the word defaults
        mask     = LANE_ALL;
        wword    = wdata;
        misalign = (addr_lo != 2'b00);
        ldata    = raw;
        case (size)
            SZ_HALF: begin
                mask     = addr_lo[1] ? LANE_HALF_HI : LANE_HALF_LO;
                wword    = {2{wdata[15:0]}};
                misalign = addr_lo[0];
                ldata    = {{16{sext & half_v[15]}}, half_v};
            end
            SZ_BYTE: begin
                mask     = LANE_BYTE0 << addr_lo;
                wword    = {4{wdata[7:0]}};
                misalign = 1'b0;
                ldata    = {{24{sext & byte_v[7]}}, byte_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_be.sv
// rtl/dm_be.sv - byte-enable data memory with clear sweep and debug display port
module dm_be
    import dm_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sweep,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              busy,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_data
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [31:0] mem [DEPTH];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      disp_data_q, disp_data_d;

    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] disp_idx;
    logic [31:0]      acc_raw;
    logic [3:0]       al_mask;
    logic [31:0]      al_wword;
    logic             al_mis;
    logic [31:0]      al_ldata;

    logic             mem_we;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_word;
    logic             unused_disp_lo;

    assign acc_idx        = addr[ADDR_W-1:2];
    assign disp_idx       = disp_addr[ADDR_W-1:2];
    assign acc_raw        = mem[acc_idx];
    assign unused_disp_lo = ^disp_addr[1:0];

    dm_align u_align (
        .size     (size),
        .addr_lo  (addr[1:0]),
        .wdata    (wdata),
        .sext     (sext),
        .raw      (acc_raw),
        .mask     (al_mask),
        .wword    (al_wword),
        .misalign (al_mis),
        .ldata    (al_ldata)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        resp_d      = 1'b0;
        rdata_d     = 32'h0;
        misalign_d  = 1'b0;
        disp_data_d = mem[disp_idx];
        mem_we      = 1'b0;
        wr_idx      = ptr_q;
        wr_mask     = LANE_ALL;
        wr_word     = INIT_VAL;

        if (state_q == ST_SWEEP) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) begin
                state_d = ST_IDLE;
            end
        end else if (sweep) begin
            // a coincident request is dropped in favour of the sweep
            state_d = ST_SWEEP;
            ptr_d   = '0;
        end else if (req) begin
            resp_d     = 1'b1;
            misalign_d = al_mis;
            if (!al_mis) begin
                if (we) begin
                    mem_we  = 1'b1;
                    wr_idx  = acc_idx;
                    wr_mask = al_mask;
                    wr_word = al_wword;
                end else begin
                    rdata_d = al_ldata;
                end
            end
        end
    end

    // No reset on the array: clr forces SWEEP, so no request write can land after it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_SWEEP;
            ptr_q       <= '0;
            resp_q      <= 1'b0;
            rdata_q     <= 32'h0;
            misalign_q  <= 1'b0;
            disp_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            disp_data_q <= disp_data_d;
        end
    end

    assign resp      = resp_q;
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign disp_data = disp_data_q;
    assign busy      = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_dm_be.sv
// tb/tb_dm_be.sv - randomized and directed checks of dm_be against a behavioural model
module tb_dm_be;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] INIT   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        sweep = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [7:0]  disp_addr = 8'h00;
    logic        resp, misalign, busy;
    logic [31:0] rdata, disp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_be #(.ADDR_W(ADDR_W), .INIT_VAL(INIT)) dut (
        .clk       (clk),
        .clr       (clr),
        .sweep     (sweep),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .resp      (resp),
        .rdata     (rdata),
        .misalign  (misalign),
        .busy      (busy),
        .disp_addr (disp_addr),
        .disp_data (disp_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: byte-level memory plus a sweep countdown
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy = 1'b1;
    int          m_ptr = 0;
    bit          e_resp = 1'b0;
    logic [31:0] e_rdata = 32'h0;
    bit          e_mis = 1'b0;
    logic [31:0] e_disp = 32'h0;
    bit          e_disp_known = 1'b1;
    int          md_off, md_wi, md_nb;
    logic [31:0] md_v, md_mask;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_busy = 1'b1; m_ptr = 0;
            e_resp = 1'b0; e_rdata = 32'h0; e_mis = 1'b0;
            e_disp = 32'h0; e_disp_known = 1'b1;
        end else begin
            e_disp       = m_mem[disp_addr / 4];
            e_disp_known = m_known[disp_addr / 4];
            e_resp = 1'b0; e_rdata = 32'h0; e_mis = 1'b0;
            if (m_busy) begin
                m_mem[m_ptr] = INIT;
                m_known[m_ptr] = 1'b1;
                m_ptr++;
                if (m_ptr == DEPTH) m_busy = 1'b0;
            end else if (sweep) begin
                m_busy = 1'b1; m_ptr = 0;
            end else if (req) begin
                md_nb  = (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : 4;
                md_off = addr % 4;
                md_wi  = addr / 4;
                e_resp = 1'b1;
                if (md_off % md_nb != 0) begin
                    e_mis = 1'b1;
                end else if (we) begin
                    for (int b = 0; b < md_nb; b++)
                        m_mem[md_wi][8*(md_off+b) +: 8] = wdata[8*b +: 8];
                end else begin
                    md_v = m_mem[md_wi] >> (8 * md_off);
                    if (md_nb < 4) begin
                        md_mask = (32'h1 << (8 * md_nb)) - 32'h1;
                        md_v = md_v & md_mask;
                        if (sext && md_v[8*md_nb-1]) md_v = md_v | ~md_mask;
                    end
                    e_rdata = md_v;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            chk("rst_resp", {31'b0, resp}, 32'd0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_misalign", {31'b0, misalign}, 32'd0);
            chk("rst_disp", disp_data, 32'h0);
            chk("rst_busy", {31'b0, busy}, 32'd1);
        end else begin
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("resp", {31'b0, resp}, {31'b0, e_resp});
            if (e_resp) begin
                chk("misalign", {31'b0, misalign}, {31'b0, e_mis});
                chk("rdata", rdata, e_rdata);
            end
            if (e_disp_known) chk("disp_data", disp_data, e_disp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [7:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
        tick();
        req = 1'b0;
    endtask

    task automatic expect_resp(input string nm, input logic [31:0] exp_rd, input logic exp_mis);
        @(negedge clk);
        chk({nm, "_resp"}, {31'b0, resp}, 32'd1);
        chk({nm, "_rdata"}, rdata, exp_rd);
        chk({nm, "_mis"}, {31'b0, misalign}, {31'b0, exp_mis});
    endtask

    task automatic count_busy(input string nm, output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!busy) break;
            if (n == 0) chk({nm, "_no_resp_busy"}, {31'b0, resp}, 32'd0);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", nm, busy, n);
        end
        req = 1'b0;
    endtask

    int n;

    initial begin
        #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd1);
        chk("reset_resp", {31'b0, resp}, 32'd0);
        @(posedge clk);
        #1 clr = 1'b0;

        req = 1'b1; we = 1'b0; size = 2'b00; addr = 8'h10;
        count_busy("sweep0", n);
        chk("sweep0_len", n, 32'd64);

        tick();
        issue(1'b0, 2'b00, 1'b0, 8'h3C, 32'h0);
        expect_resp("init_read", 32'hA5A5_A5A5, 1'b0);

        issue(1'b1, 2'b00, 1'b0, 8'h00, 32'h1122_3344);
        expect_resp("st_word", 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 8'h02, 32'h0000_00EE);
        expect_resp("st_byte", 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
        expect_resp("ld_merged", 32'h11EE_3344, 1'b0);

        issue(1'b1, 2'b00, 1'b0, 8'h04, 32'h8000_80F0);
        issue(1'b0, 2'b10, 1'b1, 8'h04, 32'h0);
        expect_resp("lb_sext", 32'hFFFF_FFF0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 8'h04, 32'h0);
        expect_resp("lb_zext", 32'h0000_00F0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 8'h06, 32'h0);
        expect_resp("lh_sext", 32'hFFFF_8000, 1'b0);

        issue(1'b1, 2'b00, 1'b0, 8'h05, 32'h1234_5678);
        expect_resp("mis_sw", 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 8'h03, 32'h0);
        expect_resp("mis_lh", 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 8'h04, 32'h0);
        expect_resp("mis_unchanged", 32'h8000_80F0, 1'b0);

        disp_addr = 8'h08;
        tick();
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 8'h08; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;
        @(negedge clk);
        chk("b2b_disp_old", disp_data, 32'hA5A5_A5A5);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("b2b_rdata", rdata, 32'hDEAD_BEEF);
        chk("b2b_resp", {31'b0, resp}, 32'd1);
        chk("b2b_disp_new", disp_data, 32'hDEAD_BEEF);

        tick();
        sweep = 1'b1; req = 1'b1; we = 1'b1; addr = 8'h0C; wdata = 32'h0BAD_0BAD;
        tick();
        sweep = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("sweep_req_resp", {31'b0, resp}, 32'd0);
        chk("sweep_req_busy", {31'b0, busy}, 32'd1);
        count_busy("sweep1", n);
        chk("sweep1_len", n + 1, 32'd64);

        tick();
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; we = 1'b0; size = 2'b00; addr = 8'(4 * i);
            tick();
        end
        req = 1'b0;
        #2 clr = 1'b1;
        @(negedge clk);
        chk("clr_cancel_resp", {31'b0, resp}, 32'd0);
        chk("clr_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1 clr = 1'b0;
        count_busy("sweep2", n);
        chk("sweep2_len", n, 32'd64);

        tick();
        for (int it = 0; it < 3000; it++) begin
            req   = ($urandom_range(0, 9) < 6);
            we    = $urandom_range(0, 1);
            size  = 2'($urandom_range(0, 3));
            sext  = $urandom_range(0, 1);
            addr  = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            wdata = $urandom;
            disp_addr = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            sweep = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 clr = 1'b1;
                @(posedge clk);
                #1 clr = 1'b0;
            end
            tick();
        end
        req = 1'b0; sweep = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_be.md
# dm_be

Parametrised byte-enable data memory for the MIPS datapath; successor to the fixed 64-word store. Single read/write port with word/half/byte access, sign- or zero-extended loads, misalignment detection and a registered one-cycle response. A read-only display port serves the debug panel, and reset starts a self-clearing sweep so the array needs no asynchronous clear.

## Interface
- ADDR_W, 8, byte-address width; DEPTH = 2^(ADDR_W-2) words of 32 bits
- INIT_VAL, 32'h0000_0000, value written to every word by the clear sweep
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-high
- sweep  in  1  synchronous request to re-run the clear sweep (ignored while busy)
- req  in  1  access request, accepted when req && !busy
- we  in  1  1 = store, 0 = load
- size  in  2  00 word, 01 half, 10 byte, 11 word
- sext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp  out  1  one-cycle pulse, response to an accepted request
- rdata  out  32  extended load result, valid with resp && !we of that request; 0 for stores
- misalign  out  1  valid with resp; request was misaligned and had no effect
- busy  out  1  sweep in progress
- disp_addr  in  ADDR_W  display byte address (word index = disp_addr[ADDR_W-1:2])
- disp_data  out  32  full word at disp_addr, registered

## Operation
- States: SWEEP, IDLE. clr asserted → SWEEP, ptr=0. In SWEEP each cycle write mem[ptr]=INIT_VAL, ptr++; after writing word DEPTH-1 → IDLE. sweep=1 in IDLE → SWEEP, ptr=0.
- busy = (state==SWEEP). Requests while busy: dropped, no resp, no side effect.
- Lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half at addr[1]=h = bits [16h+15:16h].
- Alignment: word requires addr[1:0]==0, half requires addr[0]==0, byte always aligned. Misaligned access: no write, rdata=0, misalign=1.
- Store: only selected lanes written with wdata low bits; other lanes unchanged.
- Load: selected lane shifted to bit 0, extended to 32 bits per sext; word ignores sext.
- Display port never blocked; reflects array contents including sweep progress.
- sweep and req in the same IDLE cycle: sweep wins, req dropped.

## Timing
- Reset values: resp=0, rdata=0, misalign=0, disp_data=0, busy=1 (state SWEEP, ptr=0).
- Sweep length: exactly DEPTH cycles after clr deasserts; busy falls on the cycle after the last word is written. Default: 64 cycles.
- Request latency: accepted in cycle N, resp/rdata/misalign valid in cycle N+1 for one cycle. Back-to-back requests allowed every cycle.
- Store-then-load to same word in consecutive cycles returns updated data (write in N, read in N+1 sees it).
- disp_data = mem[disp word] as of the previous edge; one cycle latency; same-cycle store not visible until following cycle.
- clr mid-access: pending resp cancelled, in-flight store does not complete if clr precedes its edge; sweep restarts from 0.

## Structure
- Package dm_pkg: size encodings (SZ_WORD, SZ_HALF, SZ_BYTE), state type (ST_SWEEP, ST_IDLE), lane-select helper constants.
- Sub-module dm_align (combinational): from size/addr/wdata/sext produces 4-bit byte mask, shifted write word, misalign flag, and load extraction from a raw word. Top holds array, FSM, sweep counter and output registers.

## Test plan
- Reset then idle: clr pulse, INIT_VAL=32'hA5A5A5A5 → busy high 64 cycles, any word reads 32'hA5A5A5A5 afterwards; req during busy gives no resp.
- Byte stores: word store 0x00 ← 32'h11223344, byte store addr 0x02 ← 8'hEE → word load 0x00 = 32'h11EE3344.
- Extension: word 0x04 = 32'h8000_80F0; byte load addr 0x04 sext=1 → 32'hFFFF_FFF0, sext=0 → 32'h0000_00F0; half load 0x06 sext=1 → 32'hFFFF_8000.
- Misalign: word store addr 0x05, half load addr 0x03 → resp with misalign=1, rdata=0, memory unchanged.
- Back-to-back: store 0x08 ← 32'hDEADBEEF in cycle N, load 0x08 in N+1 → rdata 32'hDEADBEEF in N+2; disp_addr=0x08 shows it from N+2.
- Mid-operation clr/sweep: clr during a load stream → no resp after clr, sweep restarts at word 0; sweep and req in same cycle → req dropped, busy next cycle.
